// File: rtl/exe_stage_if.sv
// ID/EX operand bundle into execute and EX/MEM bundle out of it.
// slave: execute stage side; master: decode/memory (or bench) side.
interface exe_stage_if #(
    parameter int DATA_W = 32
);
    logic              freeze;
    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic [3:0]        exe_cmd;
    logic              b;
    logic              s;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] value_rn;
    logic [DATA_W-1:0] value_rm;
    logic [11:0]       shift_operand;
    logic              imm;
    logic [23:0]       imm_signed_24;
    logic [3:0]        dest_in;

    logic              branch_taken;
    logic [DATA_W-1:0] branch_addr;
    logic [3:0]        status;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [3:0]        dest;

    modport slave (
        input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in,
        input  exe_cmd, b, s, pc, value_rn, value_rm,
        input  shift_operand, imm, imm_signed_24, dest_in,
        output branch_taken, branch_addr, status,
        output wb_en, mem_r_en, mem_w_en,
        output alu_result, st_val, dest
    );

    modport master (
        output freeze, wb_en_in, mem_r_en_in, mem_w_en_in,
        output exe_cmd, b, s, pc, value_rn, value_rm,
        output shift_operand, imm, imm_signed_24, dest_in,
        input  branch_taken, branch_addr, status,
        input  wb_en, mem_r_en, mem_w_en,
        input  alu_result, st_val, dest
    );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: val2 shifter, ALU, NZCV register, branch target.
// Ports: clk, rst (async, active-high), bus (exe_stage_if.slave).
module exe_stage #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    logic [DATA_W-1:0]   val2;
    logic [2*DATA_W-1:0] rot;
    logic [4:0]          sh;
    logic [DATA_W-1:0]   add_b;
    logic                cin;
    logic                is_sub;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   res;
    logic                c_n;
    logic                v_n;
    logic                op_ok;
    logic [3:0]          nzcv_d;
    logic [3:0]          status_q;
    logic [DATA_W-1:0]   a;

    assign a  = bus.value_rn;
    assign sh = bus.shift_operand[11:7];

    always_comb begin
        val2 = '0;
        rot  = '0;
        if (bus.mem_r_en_in || bus.mem_w_en_in) begin
            val2 = {{(DATA_W-12){1'b0}}, bus.shift_operand};
        end else if (bus.imm) begin
            // doubled word shifted right == rotate right
            rot  = {2{{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]}}
                   >> {bus.shift_operand[11:8], 1'b0};
            val2 = rot[DATA_W-1:0];
        end else begin
            unique case (bus.shift_operand[6:5])
                2'b00: val2 = bus.value_rm << sh;
                2'b01: val2 = bus.value_rm >> sh;
                2'b10: val2 = $unsigned($signed(bus.value_rm) >>> sh);
                default: begin
                    rot  = {bus.value_rm, bus.value_rm} >> sh;
                    val2 = rot[DATA_W-1:0];
                end
            endcase
        end
    end

    // One adder for all arithmetic: subtract as A + ~B + carry.
    always_comb begin
        is_sub = (bus.exe_cmd == OP_SUB) || (bus.exe_cmd == OP_SBC);
        add_b  = is_sub ? ~val2 : val2;
        cin    = (bus.exe_cmd == OP_SUB) ||
                 (((bus.exe_cmd == OP_ADC) || (bus.exe_cmd == OP_SBC)) &&
                  status_q[1]);
        sum    = {1'b0, a} + {1'b0, add_b} + {{DATA_W{1'b0}}, cin};
    end

    always_comb begin
        res   = '0;
        c_n   = status_q[1];
        v_n   = status_q[0];
        op_ok = 1'b1;
        case (bus.exe_cmd)
            OP_MOV: res = val2;
            OP_MVN: res = ~val2;
            OP_AND: res = a & val2;
            OP_ORR: res = a | val2;
            OP_EOR: res = a ^ val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                res = sum[DATA_W-1:0];
                c_n = sum[DATA_W];
                v_n = (a[DATA_W-1] == add_b[DATA_W-1]) &&
                      (sum[DATA_W-1] != a[DATA_W-1]);
            end
            default: op_ok = 1'b0;
        endcase
        nzcv_d = op_ok ? {res[DATA_W-1], res == '0, c_n, v_n} : status_q;
    end

    assign bus.branch_taken = bus.b & ~bus.freeze;
    assign bus.branch_addr  = bus.pc +
        {{(DATA_W-26){bus.imm_signed_24[23]}}, bus.imm_signed_24, 2'b00};
    assign bus.status       = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= 4'b0000;
        end else if (bus.s && !bus.freeze && !bus.b) begin
            status_q <= nzcv_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_en      <= 1'b0;
            bus.mem_r_en   <= 1'b0;
            bus.mem_w_en   <= 1'b0;
            bus.alu_result <= '0;
            bus.st_val     <= '0;
            bus.dest       <= '0;
        end else if (!bus.freeze) begin
            bus.wb_en      <= bus.wb_en_in;
            bus.mem_r_en   <= bus.mem_r_en_in;
            bus.mem_w_en   <= bus.mem_w_en_in;
            bus.alu_result <= res;
            bus.st_val     <= bus.value_rm;
            bus.dest       <= bus.dest_in;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with an expected-result queue.
// Expectations are pushed on drive and popped one cycle later.
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;

    exe_stage_if #(.DATA_W(32)) bus ();

    exe_stage #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  dst;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] st;
        logic [3:0]  nzcv;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.freeze        = 1'b0;
        bus.wb_en_in      = 1'b0;
        bus.mem_r_en_in   = 1'b0;
        bus.mem_w_en_in   = 1'b0;
        bus.exe_cmd       = 4'b0000;
        bus.b             = 1'b0;
        bus.s             = 1'b0;
        bus.pc            = 32'h0;
        bus.value_rn      = 32'h0;
        bus.value_rm      = 32'h0;
        bus.shift_operand = 12'h0;
        bus.imm           = 1'b0;
        bus.imm_signed_24 = 24'h0;
        bus.dest_in       = 4'h0;
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] dst,
                        input logic wb, input logic mr, input logic mw,
                        input logic [31:0] st, input logic [3:0] nzcv);
        exp_t e;
        e.res = res; e.dst = dst; e.wb = wb; e.mr = mr;
        e.mw = mw; e.st = st; e.nzcv = nzcv;
        q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            last = e;
            chk({tag, "_res"}, bus.alu_result, e.res);
            chk({tag, "_dst"}, {28'h0, bus.dest}, {28'h0, e.dst});
            chk({tag, "_en"},
                {29'h0, bus.wb_en, bus.mem_r_en, bus.mem_w_en},
                {29'h0, e.wb, e.mr, e.mw});
            chk({tag, "_st"}, bus.st_val, e.st);
            chk({tag, "_nzcv"}, {28'h0, bus.status}, {28'h0, e.nzcv});
        end
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        #3 rst = 1'b1;
        #1;
        chk("rst_status", {28'h0, bus.status}, 32'h0);
        chk("rst_en", {29'h0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'h0);
        chk("rst_res", bus.alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // MOV immediate 0xFF ror 8
        clr();
        bus.exe_cmd = 4'b0001; bus.imm = 1'b1; bus.shift_operand = 12'h4FF;
        bus.wb_en_in = 1'b1; bus.dest_in = 4'd3; bus.s = 1'b1;
        push(32'hFF000000, 4'd3, 1, 0, 0, 32'h0, 4'b1000);
        step("mov_imm");

        clr();
        bus.value_rn = 32'd5; bus.value_rm = 32'd5; bus.exe_cmd = 4'b0100;
        bus.s = 1'b1; bus.wb_en_in = 1'b1; bus.dest_in = 4'd4;
        push(32'h0, 4'd4, 1, 0, 0, 32'd5, 4'b0110);
        step("sub");

        clr();
        bus.value_rn = 32'd1; bus.value_rm = 32'hFFFFFFFF;
        bus.exe_cmd = 4'b0011; bus.s = 1'b1; bus.dest_in = 4'd5;
        push(32'h1, 4'd5, 0, 0, 0, 32'hFFFFFFFF, 4'b0010);
        step("adc");

        clr();
        bus.value_rm = 32'h80000000; bus.shift_operand = {5'd4, 2'b10, 5'b0};
        bus.exe_cmd = 4'b0001;
        push(32'hF8000000, 4'd0, 0, 0, 0, 32'h80000000, 4'b0010);
        step("asr");

        clr();
        bus.value_rm = 32'h000000F1; bus.shift_operand = {5'd4, 2'b11, 5'b0};
        bus.exe_cmd = 4'b0001;
        push(32'h1000000F, 4'd0, 0, 0, 0, 32'h000000F1, 4'b0010);
        step("ror");

        clr();
        bus.value_rn = 32'h7FFFFFFF; bus.value_rm = 32'd1;
        bus.exe_cmd = 4'b0010; bus.s = 1'b1;
        push(32'h80000000, 4'd0, 0, 0, 0, 32'd1, 4'b1001);
        step("add_ovf");

        // undefined opcode: zero result, flags kept
        clr();
        bus.value_rn = 32'd5; bus.value_rm = 32'd3;
        bus.exe_cmd = 4'b1010; bus.s = 1'b1;
        push(32'h0, 4'd0, 0, 0, 0, 32'd3, 4'b1001);
        step("undef");

        // C=0 so SBC gives 5-3-1
        clr();
        bus.value_rn = 32'd5; bus.value_rm = 32'd3;
        bus.exe_cmd = 4'b0101; bus.s = 1'b1;
        push(32'h1, 4'd0, 0, 0, 0, 32'd3, 4'b0010);
        step("sbc");

        clr();
        bus.pc = 32'h100; bus.imm_signed_24 = 24'hFFFFFE; bus.b = 1'b1;
        bus.s = 1'b1; bus.exe_cmd = 4'b0100; bus.value_rn = 32'd2;
        bus.value_rm = 32'd9;
        #1;
        chk("br_taken", {31'h0, bus.branch_taken}, 32'h1);
        chk("br_addr", bus.branch_addr, 32'h000000F8);
        push(32'hFFFFFFF9, 4'd0, 0, 0, 0, 32'd9, 4'b0010);
        step("branch");

        clr();
        bus.freeze = 1'b1; bus.b = 1'b1; bus.s = 1'b1; bus.wb_en_in = 1'b1;
        bus.exe_cmd = 4'b0001; bus.imm = 1'b1; bus.shift_operand = 12'h0FF;
        bus.dest_in = 4'd9; bus.value_rm = 32'h55;
        #1;
        chk("frz_taken", {31'h0, bus.branch_taken}, 32'h0);
        push(last.res, last.dst, last.wb, last.mr, last.mw, last.st, last.nzcv);
        step("freeze");

        clr();
        bus.mem_r_en_in = 1'b1; bus.value_rn = 32'h400;
        bus.shift_operand = 12'h804; bus.exe_cmd = 4'b0010;
        bus.value_rm = 32'hDEADBEEF; bus.dest_in = 4'd7; bus.wb_en_in = 1'b1;
        push(32'h00000C04, 4'd7, 1, 1, 0, 32'hDEADBEEF, 4'b0010);
        step("load");

        clr();
        bus.mem_w_en_in = 1'b1; bus.value_rn = 32'h10;
        bus.shift_operand = 12'hFFF; bus.exe_cmd = 4'b0010;
        bus.value_rm = 32'h12345678; bus.dest_in = 4'd2;
        push(32'h0000100F, 4'd2, 0, 0, 1, 32'h12345678, 4'b0010);
        step("store");

        // reset mid-cycle with live inputs, then a bubble
        clr();
        bus.wb_en_in = 1'b1; bus.s = 1'b1; bus.exe_cmd = 4'b0001;
        bus.imm = 1'b1; bus.shift_operand = 12'h0AB; bus.dest_in = 4'd6;
        #2 rst = 1'b1;
        #1;
        chk("rst2_status", {28'h0, bus.status}, 32'h0);
        chk("rst2_res", bus.alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clr();
        push(32'h0, 4'd0, 0, 0, 0, 32'h0, 4'b0000);
        step("bubble");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
